// File: rtl/mem_port_arbiter_pkg.sv
// mem_port_arbiter_pkg: shared widths, FSM states, owner/length codes and a saturating increment for the memory port arbiter
package mem_port_arbiter_pkg;
    localparam int ADDR_L = 32;
    localparam int DATA_L = 32;
    typedef enum logic [1:0] {ST_IDLE, ST_GNT_IF, ST_GNT_MEM, ST_RESP} state_t;
    typedef enum logic [1:0] {LEN_BYTE = 2'd0, LEN_HALF = 2'd1, LEN_WORD = 2'd3} len_t;
    localparam logic [1:0] OWN_NONE = 2'd0;
    localparam logic [1:0] OWN_IF = 2'd1;
    localparam logic [1:0] OWN_MEM = 2'd2;
    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction
endpackage

// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: IF/MEM request side plus RAM side of the shared port; slave = arbiter, master = pipeline stages and RAM model
interface mem_port_arbiter_if;
    import mem_port_arbiter_pkg::*;
    logic              if_re;
    logic [ADDR_L-1:0] if_addr;
    logic [1:0]        if_rlen;
    logic              if_rack;
    logic [DATA_L-1:0] if_data;
    logic              mem_re;
    logic              mem_we;
    logic [ADDR_L-1:0] mem_addr;
    logic [1:0]        mem_len;
    logic [DATA_L-1:0] mem_wdata;
    logic              mem_rack;
    logic              mem_wack;
    logic [DATA_L-1:0] mem_rdata;
    logic              ram_re;
    logic              ram_we;
    logic [ADDR_L-1:0] ram_addr;
    logic [1:0]        ram_len;
    logic [DATA_L-1:0] ram_wdata;
    logic              ram_rack;
    logic              ram_wack;
    logic [DATA_L-1:0] ram_rdata;
    logic [1:0]        owner;
    logic [15:0]       if_wait_cnt;
    modport slave (
        input  if_re, if_addr, if_rlen, mem_re, mem_we, mem_addr, mem_len, mem_wdata,
               ram_rack, ram_wack, ram_rdata,
        output if_rack, if_data, mem_rack, mem_wack, mem_rdata,
               ram_re, ram_we, ram_addr, ram_len, ram_wdata, owner, if_wait_cnt
    );
    modport master (
        output if_re, if_addr, if_rlen, mem_re, mem_we, mem_addr, mem_len, mem_wdata,
               ram_rack, ram_wack, ram_rdata,
        input  if_rack, if_data, mem_rack, mem_wack, mem_rdata,
               ram_re, ram_we, ram_addr, ram_len, ram_wdata, owner, if_wait_cnt
    );
endinterface

// File: rtl/mem_port_arbiter_arb_pick.sv
// arb_pick: winner select (clk, rst, i_if_req, i_mem_req, i_take in; o_pick_mem out), MEM priority by default, round-robin on ties when ARB_RR_EN is defined
module arb_pick (
    input  logic clk,
    input  logic rst,
    input  logic i_if_req,
    input  logic i_mem_req,
    input  logic i_take,
    output logic o_pick_mem
);
`ifdef ARB_RR_EN
    localparam logic RR = 1'b1;
`else
    localparam logic RR = 1'b0;
`endif
    logic r_ptr;
    assign o_pick_mem = i_mem_req && !(i_if_req && RR && r_ptr);
    always_ff @(posedge clk) r_ptr <= rst ? 1'b0 : (i_take ? o_pick_mem : r_ptr);
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between IF and MEM (clk, rst, bus slave: requests in; ram strobes, acks, read data, owner, if_wait_cnt out); round-robin when ARB_RR_EN is defined
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
(
    input logic               clk,
    input logic               rst,
    mem_port_arbiter_if.slave bus
);
    state_t            r_state, w_next;
    logic              r_we, r_ram_re, r_ram_we, r_if_rack, r_mem_rack, r_mem_wack;
    logic [ADDR_L-1:0] r_ram_addr;
    logic [1:0]        r_ram_len, r_owner;
    logic [DATA_L-1:0] r_ram_wdata, r_if_data, r_mem_rdata;
    logic [15:0]       r_wait;
    logic              w_if_req, w_mem_req, w_pick_mem, w_take, w_done, w_wr;
    assign w_if_req  = bus.if_re;
    assign w_mem_req = bus.mem_re | bus.mem_we;
    assign w_take    = (r_state == ST_IDLE) && (w_if_req || w_mem_req);
    assign w_wr      = w_pick_mem && bus.mem_we;
    assign w_done    = (r_state == ST_GNT_IF || r_state == ST_GNT_MEM) && (r_we ? bus.ram_wack : bus.ram_rack);
    arb_pick u_pick (
        .clk        (clk),
        .rst        (rst),
        .i_if_req   (w_if_req),
        .i_mem_req  (w_mem_req),
        .i_take     (w_take),
        .o_pick_mem (w_pick_mem)
    );
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:               w_next = w_take ? (w_pick_mem ? ST_GNT_MEM : ST_GNT_IF) : ST_IDLE;
            ST_GNT_IF, ST_GNT_MEM: w_next = w_done ? ST_RESP : r_state;
            default:               w_next = ST_IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_we        <= 1'b0;
            r_ram_re    <= 1'b0;
            r_ram_we    <= 1'b0;
            r_ram_addr  <= '0;
            r_ram_len   <= '0;
            r_ram_wdata <= '0;
            r_if_rack   <= 1'b0;
            r_mem_rack  <= 1'b0;
            r_mem_wack  <= 1'b0;
            r_if_data   <= '0;
            r_mem_rdata <= '0;
            r_owner     <= OWN_NONE;
            r_wait      <= '0;
        end else begin
            r_state    <= w_next;
            r_if_rack  <= w_done && r_owner == OWN_IF;
            r_mem_rack <= w_done && r_owner == OWN_MEM && !r_we;
            r_mem_wack <= w_done && r_we;
            r_wait     <= (bus.if_re && r_owner != OWN_IF && r_state != ST_RESP) ? sat_inc(r_wait) : r_wait;
            if (w_take) begin
                r_we        <= w_wr;
                r_ram_re    <= !w_wr;
                r_ram_we    <= w_wr;
                r_ram_addr  <= w_pick_mem ? bus.mem_addr : bus.if_addr;
                r_ram_len   <= w_pick_mem ? bus.mem_len : bus.if_rlen;
                r_ram_wdata <= w_pick_mem ? bus.mem_wdata : '0;
                r_owner     <= w_pick_mem ? OWN_MEM : OWN_IF;
            end
            if (w_done) begin
                r_ram_re <= 1'b0;
                r_ram_we <= 1'b0;
            end
            if (w_done && !r_we && r_owner == OWN_IF) r_if_data <= bus.ram_rdata;
            if (w_done && !r_we && r_owner == OWN_MEM) r_mem_rdata <= bus.ram_rdata;
            if (r_state == ST_RESP) r_owner <= OWN_NONE;
        end
    end
    assign bus.ram_re      = r_ram_re;
    assign bus.ram_we      = r_ram_we;
    assign bus.ram_addr    = r_ram_addr;
    assign bus.ram_len     = r_ram_len;
    assign bus.ram_wdata   = r_ram_wdata;
    assign bus.if_rack     = r_if_rack;
    assign bus.if_data     = r_if_data;
    assign bus.mem_rack    = r_mem_rack;
    assign bus.mem_wack    = r_mem_wack;
    assign bus.mem_rdata   = r_mem_rdata;
    assign bus.owner       = r_owner;
    assign bus.if_wait_cnt = r_wait;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: table-driven vectors, hand sequences and an ack scoreboard for mem_port_arbiter (ARB_RR_EN aware)
module tb_mem_port_arbiter;
    import mem_port_arbiter_pkg::*;
`ifdef ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif
    typedef struct {
        bit          ifr;
        bit          mr;
        bit          mw;
        logic [31:0] ia;
        logic [31:0] ma;
        logic [1:0]  len;
        logic [31:0] wd;
        int          lat;
        logic [31:0] if_exp;
        logic [31:0] mem_exp;
    } vec_t;
    typedef struct {
        int          kind;
        logic [31:0] data;
    } exp_t;
    logic clk = 1'b0;
    logic rst = 1'b1;
    mem_port_arbiter_if bus();
    mem_port_arbiter dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );
    always #5 clk = ~clk;
    int          total = 0;
    int          bad = 0;
    int          lat = 1;
    int          n_acks = 0;
    int          rcnt = 0;
    int          na = 0;
    bit          ram_hold = 0;
    bit          mon_free = 0;
    bit          tb_ptr = 0;
    bit          p_if = 0;
    bit          p_mem = 0;
    logic [31:0] last_wdata = '0;
    exp_t        sb[$];
    vec_t        vt[8];
    function automatic logic [31:0] mem_val(input logic [31:0] a);
        return (a == 32'h1000) ? 32'h0000_0013 : ~a;
    endfunction
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic push(input int kind, input logic [31:0] d);
        exp_t e;
        e.kind = kind;
        e.data = d;
        sb.push_back(e);
    endtask
    task automatic drain(input int max);
        for (int i = 0; i < max && (p_if || p_mem); i++) begin
            tick();
            if (bus.if_rack) begin
                bus.if_re = 1'b0;
                p_if = 1'b0;
            end
            if (bus.mem_rack || bus.mem_wack) begin
                bus.mem_re = 1'b0;
                bus.mem_we = 1'b0;
                p_mem = 1'b0;
            end
        end
        chk("drain_timeout", {30'd0, p_if, p_mem}, 32'd0);
        bus.if_re = 1'b0;
        bus.mem_re = 1'b0;
        bus.mem_we = 1'b0;
        p_if = 1'b0;
        p_mem = 1'b0;
        tick();
    endtask
    task automatic do_reset();
        rst = 1'b1;
        bus.if_re = 1'b0;
        bus.mem_re = 1'b0;
        bus.mem_we = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        tb_ptr = 1'b0;
        chk("rst_owner", {30'd0, bus.owner}, 32'd0);
        chk("rst_strobes", {30'd0, bus.ram_re, bus.ram_we}, 32'd0);
        chk("rst_acks", {29'd0, bus.if_rack, bus.mem_rack, bus.mem_wack}, 32'd0);
        chk("rst_ram_addr", bus.ram_addr, 32'd0);
        chk("rst_ram_len", {30'd0, bus.ram_len}, 32'd0);
        chk("rst_ram_wdata", bus.ram_wdata, 32'd0);
        chk("rst_if_data", bus.if_data, 32'd0);
        chk("rst_mem_rdata", bus.mem_rdata, 32'd0);
        chk("rst_wait_cnt", {16'd0, bus.if_wait_cnt}, 32'd0);
    endtask
    initial begin
        forever begin
            @(posedge clk);
            #1;
            bus.ram_rack = 1'b0;
            bus.ram_wack = 1'b0;
            if (!(bus.ram_re || bus.ram_we)) rcnt = 0;
            else if (!ram_hold) begin
                rcnt++;
                if (rcnt >= lat) begin
                    rcnt = 0;
                    if (bus.ram_we) begin
                        bus.ram_wack = 1'b1;
                        last_wdata = bus.ram_wdata;
                    end else begin
                        bus.ram_rack = 1'b1;
                        bus.ram_rdata = mem_val(bus.ram_addr);
                    end
                end
            end
        end
    end
    initial begin
        forever begin
            @(posedge clk);
            #2;
            if (bus.if_rack || bus.mem_rack || bus.mem_wack) begin
                int k;
                logic [31:0] d;
                exp_t e;
                n_acks++;
                chk("ack_onehot", {29'd0, bus.if_rack, bus.mem_rack, bus.mem_wack} & ({29'd0, bus.if_rack, bus.mem_rack, bus.mem_wack} - 32'd1), 32'd0);
                k = bus.if_rack ? 0 : (bus.mem_rack ? 1 : 2);
                d = (k == 0) ? bus.if_data : ((k == 1) ? bus.mem_rdata : last_wdata);
                if (!mon_free) begin
                    if (sb.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL ack_unexpected: got kind %0d data %h want no ack", k, d);
                    end else begin
                        e = sb.pop_front();
                        chk("ack_kind", k, e.kind);
                        chk("ack_data", d, e.data);
                    end
                end
            end
        end
    end
    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish want finish before time limit");
        $fatal(1, "watchdog expired");
    end
    initial begin
        bus.if_re = 1'b0;
        bus.if_addr = '0;
        bus.if_rlen = '0;
        bus.mem_re = 1'b0;
        bus.mem_we = 1'b0;
        bus.mem_addr = '0;
        bus.mem_len = '0;
        bus.mem_wdata = '0;
        bus.ram_rack = 1'b0;
        bus.ram_wack = 1'b0;
        bus.ram_rdata = '0;
        vt[0] = '{1, 0, 0, 32'h1000, 32'h0,    2'd3, 32'h0,         1, 32'h0000_0013, 32'h0};
        vt[1] = '{0, 1, 0, 32'h0,    32'h2004, 2'd3, 32'h0,         2, 32'h0,         32'hFFFF_DFFB};
        vt[2] = '{0, 0, 1, 32'h0,    32'h3000, 2'd3, 32'h1234_5678, 3, 32'h0,         32'h1234_5678};
        vt[3] = '{1, 1, 0, 32'h1004, 32'h4000, 2'd3, 32'h0,         1, 32'hFFFF_EFFB, 32'hFFFF_BFFF};
        vt[4] = '{0, 1, 0, 32'h0,    32'h10,   2'd1, 32'h0,         1, 32'h0,         32'hFFFF_FFEF};
        vt[5] = '{1, 0, 1, 32'h20,   32'h30,   2'd3, 32'hCAFE_F00D, 2, 32'hFFFF_FFDF, 32'hCAFE_F00D};
        vt[6] = '{1, 1, 1, 32'h40,   32'h50,   2'd0, 32'h0BAD_F00D, 1, 32'hFFFF_FFBF, 32'h0BAD_F00D};
        vt[7] = '{1, 0, 0, 32'h1000, 32'h0,    2'd3, 32'h0,         5, 32'h0000_0013, 32'h0};
        do_reset();
        lat = 1;
        bus.if_re = 1'b1;
        bus.if_addr = 32'h1000;
        bus.if_rlen = 2'd3;
        bus.mem_re = 1'b1;
        bus.mem_addr = 32'h2004;
        bus.mem_len = 2'd3;
        p_if = 1'b1;
        p_mem = 1'b1;
        push(1, 32'hFFFF_DFFB);
        push(0, 32'h0000_0013);
        tick();
        chk("tie_first_owner", {30'd0, bus.owner}, 32'd2);
        drain(100);
        chk("tie_wait_cnt", {16'd0, bus.if_wait_cnt}, 32'd3);
        do_reset();
        bus.if_re = 1'b1;
        bus.if_addr = 32'h1000;
        bus.if_rlen = 2'd3;
        push(0, 32'h0000_0013);
        tick();
        chk("ifo_c1_ram_re", {31'd0, bus.ram_re}, 32'd1);
        chk("ifo_c1_owner", {30'd0, bus.owner}, 32'd1);
        chk("ifo_c1_ram_addr", bus.ram_addr, 32'h1000);
        tick();
        chk("ifo_c2_rack", {31'd0, bus.if_rack}, 32'd1);
        chk("ifo_c2_data", bus.if_data, 32'h0000_0013);
        chk("ifo_c2_owner", {30'd0, bus.owner}, 32'd1);
        chk("ifo_c2_ram_re", {31'd0, bus.ram_re}, 32'd0);
        bus.if_re = 1'b0;
        tick();
        chk("ifo_c3_rack", {31'd0, bus.if_rack}, 32'd0);
        chk("ifo_c3_owner", {30'd0, bus.owner}, 32'd0);
        chk("ifo_c3_data_held", bus.if_data, 32'h0000_0013);
        for (int v = 0; v < 8; v++) begin
            bit pm;
            bit hm;
            lat = vt[v].lat;
            hm = vt[v].mr || vt[v].mw;
            pm = hm && !(vt[v].ifr && RR && tb_ptr);
            bus.if_re = vt[v].ifr;
            bus.if_addr = vt[v].ia;
            bus.if_rlen = vt[v].len;
            bus.mem_re = vt[v].mr;
            bus.mem_we = vt[v].mw;
            bus.mem_addr = vt[v].ma;
            bus.mem_len = vt[v].len;
            bus.mem_wdata = vt[v].wd;
            p_if = vt[v].ifr;
            p_mem = hm;
            if (pm) push(vt[v].mw ? 2 : 1, vt[v].mem_exp);
            if (vt[v].ifr) push(0, vt[v].if_exp);
            if (hm && !pm) push(vt[v].mw ? 2 : 1, vt[v].mem_exp);
            tick();
            chk($sformatf("v%0d_owner", v), {30'd0, bus.owner}, pm ? 32'd2 : 32'd1);
            chk($sformatf("v%0d_ram_addr", v), bus.ram_addr, pm ? vt[v].ma : vt[v].ia);
            chk($sformatf("v%0d_ram_len", v), {30'd0, bus.ram_len}, {30'd0, vt[v].len});
            chk($sformatf("v%0d_strobes", v), {30'd0, bus.ram_re, bus.ram_we}, (pm && vt[v].mw) ? 32'd1 : 32'd2);
            drain(200);
            tb_ptr = (vt[v].ifr && hm) ? !pm : pm;
        end
        lat = 4;
        bus.mem_we = 1'b1;
        bus.mem_addr = 32'h2000;
        bus.mem_len = 2'd3;
        bus.mem_wdata = 32'hDEAD_BEEF;
        p_mem = 1'b1;
        push(2, 32'hDEAD_BEEF);
        tick();
        chk("wr_ram_we", {31'd0, bus.ram_we}, 32'd1);
        chk("wr_ram_re", {31'd0, bus.ram_re}, 32'd0);
        bus.mem_wdata = 32'h0;
        bus.mem_addr = 32'h0;
        tick();
        tick();
        chk("wr_wdata_stable", bus.ram_wdata, 32'hDEAD_BEEF);
        chk("wr_addr_stable", bus.ram_addr, 32'h2000);
        na = n_acks;
        drain(50);
        chk("wr_ack_count", n_acks - na, 32'd1);
        ram_hold = 1'b1;
        bus.mem_we = 1'b1;
        bus.mem_addr = 32'h2100;
        bus.mem_wdata = 32'h1;
        tick();
        chk("rg_ram_we", {31'd0, bus.ram_we}, 32'd1);
        chk("rg_owner", {30'd0, bus.owner}, 32'd2);
        tick();
        na = n_acks;
        rst = 1'b1;
        bus.mem_we = 1'b0;
        tick();
        chk("rg_ram_we_drop", {31'd0, bus.ram_we}, 32'd0);
        chk("rg_owner_clear", {30'd0, bus.owner}, 32'd0);
        do_reset();
        ram_hold = 1'b0;
        repeat (5) tick();
        chk("rg_no_ack", n_acks - na, 32'd0);
`ifndef ARB_RR_EN
        mon_free = 1'b1;
        lat = 20;
        bus.if_re = 1'b1;
        bus.if_addr = 32'h1000;
        bus.mem_re = 1'b1;
        bus.mem_addr = 32'h10;
        repeat (70000) tick();
        chk("sat_cnt", {16'd0, bus.if_wait_cnt}, 32'h0000_FFFF);
        bus.mem_re = 1'b0;
        p_if = 1'b1;
        drain(200);
        chk("sat_hold", {16'd0, bus.if_wait_cnt}, 32'h0000_FFFF);
        mon_free = 1'b0;
`endif
        repeat (3) tick();
        chk("sb_empty", sb.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
